// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types and arbiter defaults.
package cpu_types_pkg;

  localparam int WORD_W          = 32;
  localparam int MAX_DSTREAK_DEF = 4;
  localparam int TIMEOUT_DEF     = 255;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    ISERV,
    DSERV,
    ERR
  } arbstate_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the arbiter's CPU-facing and RAM-facing signals.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              CLK;
  logic              nRST;
  logic              halt;
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] iload;
  logic              iwait;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic [DATA_W-1:0] dload;
  logic              dwait;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ramready;
  logic              ramerror;
  logic              arb_err;

  modport arb (
    input  CLK, nRST, halt, iREN, iaddr, dREN, dWEN, daddr, dstore,
           ramload, ramready, ramerror,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, arb_err
  );

  modport cpu (
    input  iload, iwait, dload, dwait, arb_err,
    output halt, iREN, iaddr, dREN, dWEN, daddr, dstore
  );

  modport ram (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramready, ramerror
  );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between fetch and data requesters; data has priority,
// bounded by a streak counter, with a per-access watchdog into a sticky ERR.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W      = WORD_W,
  parameter int DATA_W      = WORD_W,
  parameter int MAX_DSTREAK = MAX_DSTREAK_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              halt,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramready,
  input  logic              ramerror,
  output logic              arb_err
);

  localparam int DS_W = $clog2(MAX_DSTREAK + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [DS_W-1:0] DS_MAX = DS_W'(MAX_DSTREAK);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  arbstate_t         state;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_store;
  logic              lat_wr;
  logic [DS_W-1:0]   dstreak;
  logic [WD_W-1:0]   wdog;
  logic              err_q;

  logic dreq, ireq, streak_full, grant_d, grant_i, serving, done, wd_expire;

  always_comb begin
    dreq        = dREN | dWEN;
    ireq        = iREN & ~halt;
    streak_full = (dstreak == DS_MAX);
    grant_d     = dreq & ~(ireq & streak_full);
    grant_i     = ~grant_d & ireq;
    serving     = (state == ISERV) || (state == DSERV);
    // a simultaneous ramerror overrides ramready, so the requester keeps waiting
    done        = ramready & ~ramerror;
    wd_expire   = ((wdog + WD_W'(1)) == WD_MAX);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_store <= '0;
      lat_wr    <= 1'b0;
      dstreak   <= '0;
      wdog      <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wdog <= '0;
          if (grant_d) begin
            state     <= DSERV;
            lat_addr  <= daddr;
            lat_store <= dstore;
            lat_wr    <= dWEN;
            dstreak   <= streak_full ? dstreak : dstreak + DS_W'(1);
          end else if (grant_i) begin
            state     <= ISERV;
            lat_addr  <= iaddr;
            lat_store <= '0;
            lat_wr    <= 1'b0;
            dstreak   <= '0;
          end else begin
            dstreak <= '0;
          end
        end
        ISERV, DSERV: begin
          if (ramerror || (!ramready && wd_expire)) begin
            state <= ERR;
            err_q <= 1'b1;
          end else if (ramready) begin
            state <= IDLE;
            wdog  <= '0;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        ERR:     state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ramREN   = serving & ~lat_wr;
    ramWEN   = serving & lat_wr;
    ramaddr  = serving ? lat_addr : '0;
    ramstore = serving ? lat_store : '0;
    iwait    = iREN & ~((state == ISERV) & done);
    dwait    = dreq & ~((state == DSERV) & done);
    iload    = ramload;
    dload    = ramload;
    arb_err  = err_q;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared RAM port between the instruction-fetch requester and the data requester.
- The fetch side is driven by the control unit's imemREN. The data side is driven by dmemREN/MemWr.
- Data has priority. A bounded streak counter prevents fetch starvation.
- A per-access watchdog flags a RAM that never responds.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_DSTREAK, 4, consecutive data grants allowed while a fetch is pending
TIMEOUT, 255, cycles in a service state without ramready/ramerror before entering ERR

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  synchronous, active-low reset.
- halt  in  1  CPU halted. Blocks new fetch grants; data grants continue.
- iREN  in  1  fetch request.
- iaddr  in  ADDR_W  fetch address.
- iload  out  DATA_W  fetch data. Valid only when iwait=0 and iREN=1.
- iwait  out  1  fetch stall.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  write data.
- dload  out  DATA_W  read data. Valid only when dwait=0 and dREN=1.
- dwait  out  1  data stall.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramready  in  1  RAM completes the current access this cycle.
- ramerror  in  1  RAM access fault.
- arb_err  out  1  sticky: watchdog expiry or ramerror seen.

Behaviour:
- Reset: synchronous, active-low, sampled on rising CLK; applies mid-access too.
  - On the first edge with nRST=0: state=IDLE, all latches 0, dstreak=0, wdog=0, arb_err=0.
  - ramREN/ramWEN=0 from that edge. Any in-flight access is abandoned.
- State machine, arbstate_t: IDLE, ISERV, DSERV, ERR.
- IDLE arbitration, decided combinationally and registered at the edge:
  - dreq = dREN|dWEN; ireq = iREN & ~halt.
  - If dreq & ~(ireq & dstreak==MAX_DSTREAK): grant data, go to DSERV, dstreak+1 (saturating).
  - Else if ireq: grant fetch, go to ISERV, dstreak=0.
  - Else: stay IDLE. dstreak=0 whenever dreq=0.
- Latching on grant: address, write flag and store data are captured at the grant edge. Requesters hold their inputs until wait drops; later changes are ignored.
- dREN and dWEN both high: treated as a write.
- RAM drive:
  - In ISERV/DSERV: ramaddr/ramstore come from the latches; ramREN=~wr, ramWEN=wr. ISERV is always a read.
  - In IDLE/ERR: both strobes 0, ramaddr=0, ramstore=0.
- Completion: in a service state with ramready=1:
  - Requester wait=0 that cycle; iload/dload = ramload (combinational pass-through).
  - Next state IDLE; wdog=0.
- Wait outputs:
  - iwait = iREN & ~(state==ISERV & ramready).
  - dwait = (dREN|dWEN) & ~(state==DSERV & ramready).
  - Minimum latency: request seen in IDLE at cycle 0, RAM ready at cycle 1, wait low at cycle 1. One IDLE bubble between consecutive accesses.
- Requester drops its request mid-service: the access still completes on the RAM and the result is discarded. Writes are never aborted.
- Watchdog: wdog increments each service cycle without ramready.
  - If ramerror=1, or wdog reaches TIMEOUT: go to ERR, arb_err=1.
  - ramready and ramerror in the same cycle: error wins.
- ERR: absorbing until reset. Strobes low; iwait/dwait follow the request lines (held high while requested).
- halt asserted during ISERV: the current fetch completes; no further fetch grants.

Decomposition:
- In cpu_types_pkg:
  - arbstate_t enum.
  - Existing word_t for addresses and data (ADDR_W = DATA_W = 32 default).
  - Localparams for MAX_DSTREAK and TIMEOUT defaults.
- No sub-module required. The watchdog is an inline counter of width $clog2(TIMEOUT+1).
- Add a mem_arbiter_if interface with modports arb, cpu, ram.

Test Plan:
- Fetch only:
  - Stimulus: iREN=1, iaddr=0x100, RAM returns ramready after 2 cycles with ramload=0xDEADBEEF.
  - Response: ramREN=1, ramaddr=0x100 from cycle 1; iwait=0 with iload=0xDEADBEEF at cycle 2.
- Simultaneous requests:
  - Stimulus: iREN and dWEN both high at cycle 0, daddr=0x200, dstore=0x5A5A5A5A, ramready=1 every service cycle.
  - Response: DSERV first with ramWEN=1, ramstore=0x5A5A5A5A; dwait=0 at cycle 1; ISERV grant at cycle 2.
- Starvation guard:
  - Stimulus: dREN and iREN held high continuously, ramready=1.
  - Response: grant sequence D,D,D,D,I,D,D,D,D,I.
- Halt:
  - Stimulus: halt=1 with iREN=1, no data request.
  - Response: state stays IDLE, ramREN=0, iwait=1. A dREN issued during halt is still served.
- Watchdog:
  - Stimulus: dREN=1, ramready held 0.
  - Response: after TIMEOUT service cycles, state=ERR, arb_err=1, strobes 0, dwait=1. ramerror=1 mid-access instead gives ERR on the next edge.
- Reset mid-access:
  - Stimulus: nRST=0 during DSERV write.
  - Response: on the next rising edge ramWEN=0, state=IDLE, arb_err=0. A normal fetch afterwards completes.
